// File: rtl/map_pkg.sv
// Shared screen geometry, colour/address widths, screen indices and FSM encoding
// for the background-restore engine.
package map_pkg;

   localparam int unsigned SCREEN_W = 160;
   localparam int unsigned SCREEN_H = 120;
   localparam int unsigned COL_W    = 9;
   localparam int unsigned ADDR_W   = 15;

   localparam int unsigned SCR_MAP1  = 0;
   localparam int unsigned SCR_MAP2  = 1;
   localparam int unsigned SCR_START = 2;

   typedef enum logic [1:0] {StIdle, StScan, StDrain, StDone} state_e;

   // Per-pixel record travelling alongside the memory read.
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic       plot;
   } pix_meta_t;

endpackage

// File: rtl/pixel_delay_line.sv
// Fixed-depth shift register that keeps pixel coordinates and plot-enable aligned
// with background memory read data.
module pixel_delay_line #(
   parameter int unsigned DEPTH  = 1,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [DATA_W-1:0] data_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= data_i;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sprite_bg_restore.sv
// Erases a sprite by scanning its rectangle and replotting the stored background
// colour for every on-screen pixel, compensating for memory read latency.
module sprite_bg_restore #(
   parameter int unsigned SPR_W       = 15,
   parameter int unsigned SPR_H       = 15,
   parameter int unsigned SCREEN_W    = map_pkg::SCREEN_W,
   parameter int unsigned SCREEN_H    = map_pkg::SCREEN_H,
   parameter int unsigned NUM_SCREENS = 3,
   parameter int unsigned MEM_LAT     = 1,
   parameter int unsigned COL_W       = map_pkg::COL_W,
   parameter int unsigned ADDR_W      = map_pkg::ADDR_W
) (
   input  logic                         iClock,
   input  logic                         iResetn,
   input  logic                         iStart,
   input  logic [7:0]                   iX,
   input  logic [6:0]                   iY,
   input  logic [1:0]                   iScreenSel,
   input  logic [NUM_SCREENS*COL_W-1:0] iMemData,
   output logic [ADDR_W-1:0]            oAddress,
   output logic [7:0]                   oX,
   output logic [6:0]                   oY,
   output logic [COL_W-1:0]             oColour,
   output logic                         oPlot,
   output logic                         oBusy,
   output logic                         oDone
);

   import map_pkg::*;

   localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   state_e            state_q, state_d;
   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [7:0]        rx_q, rx_d;
   logic [6:0]        ry_q, ry_d;
   logic [1:0]        sel_q, sel_d;
   logic [2:0]        drain_q, drain_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   pix_meta_t         meta_q, meta_d;
   pix_meta_t         meta_dly;

   logic [7:0]        bx;
   logic [6:0]        by;
   logic              emit;
   logic [8:0]        px;
   logic [7:0]        py;
   logic              clipped;
   logic [COL_W-1:0]  colour;

   logic [7:0]        x_q;
   logic [6:0]        y_q;
   logic [COL_W-1:0]  colour_q;
   logic              plot_q;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      rx_d    = rx_q;
      ry_d    = ry_q;
      sel_d   = sel_q;
      drain_d = drain_q;
      emit    = 1'b0;
      bx      = rx_q;
      by      = ry_q;
      unique case (state_q)
         StIdle: begin
            if (iStart) begin
               state_d = StScan;
               rx_d    = iX;
               ry_d    = iY;
               sel_d   = (32'(iScreenSel) < NUM_SCREENS) ? iScreenSel : 2'(SCR_MAP1);
               col_d   = '0;
               row_d   = '0;
               drain_d = '0;
               emit    = 1'b1;
               bx      = iX;
               by      = iY;
            end
         end
         StScan: begin
            if (col_q == CW'(SPR_W - 1)) begin
               col_d = '0;
               if (row_q == RW'(SPR_H - 1)) begin
                  state_d = StDrain;
               end else begin
                  row_d = row_q + 1'b1;
                  emit  = 1'b1;
               end
            end else begin
               col_d = col_q + 1'b1;
               emit  = 1'b1;
            end
         end
         // Covers the memory latency plus the output register stage.
         StDrain: begin
            if (drain_q == 3'(MEM_LAT)) state_d = StDone;
            else                        drain_d = drain_q + 1'b1;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      px      = {1'b0, bx} + 9'(col_d);
      py      = {1'b0, by} + 8'(row_d);
      clipped = (32'(px) >= SCREEN_W) || (32'(py) >= SCREEN_H);
      addr_d  = (emit && !clipped) ?
                ADDR_W'(py) * ADDR_W'(SCREEN_W) + ADDR_W'(px) : '0;
      meta_d  = '{x: px[7:0], y: py[6:0], plot: emit && !clipped};
   end

   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         state_q <= StIdle;
         col_q   <= '0;
         row_q   <= '0;
         rx_q    <= '0;
         ry_q    <= '0;
         sel_q   <= '0;
         drain_q <= '0;
         addr_q  <= '0;
         meta_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         rx_q    <= rx_d;
         ry_q    <= ry_d;
         sel_q   <= sel_d;
         drain_q <= drain_d;
         addr_q  <= addr_d;
         meta_q  <= meta_d;
      end
   end

   pixel_delay_line #(
      .DEPTH  (MEM_LAT),
      .DATA_W ($bits(pix_meta_t))
   ) u_delay (
      .clk_i  (iClock),
      .rst_ni (iResetn),
      .data_i (meta_q),
      .data_o (meta_dly)
   );

   always_comb begin
      colour = '0;
      for (int s = 0; s < NUM_SCREENS; s++) begin
         if (sel_q == 2'(s)) colour = iMemData[s*COL_W +: COL_W];
      end
   end

   always_ff @(posedge iClock or negedge iResetn) begin
      if (!iResetn) begin
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
      end else begin
         plot_q <= meta_dly.plot;
         if (meta_dly.plot) begin
            x_q      <= meta_dly.x;
            y_q      <= meta_dly.y;
            colour_q <= colour;
         end
      end
   end

   assign oAddress = addr_q;
   assign oX       = x_q;
   assign oY       = y_q;
   assign oColour  = colour_q;
   assign oPlot    = plot_q;
   assign oBusy    = (state_q == StScan) || (state_q == StDrain);
   assign oDone    = (state_q == StDone);

endmodule

// File: tb/tb_sprite_bg_restore.sv
// Randomised self-checking bench: a 15x15/latency-1 instance and a 4x2/latency-3
// instance, both compared against a plain-arithmetic model of the scan.
module tb_sprite_bg_restore;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [1:0]       start;
   logic [7:0]       ix;
   logic [6:0]       iy;
   logic [1:0]       isel;
   logic [1:0][26:0] mem;
   logic [1:0][14:0] oaddr;
   logic [1:0][7:0]  ox;
   logic [1:0][6:0]  oy;
   logic [1:0][8:0]  ocol;
   logic [1:0]       oplot, obusy, odone;

   int errors = 0;
   int checks = 0;

   bit         const_mode;
   logic [8:0] key [3];

   // Background memories: read data appears MEM_LAT cycles after the address.
   logic [14:0] p0;
   logic [14:0] p1 [3];
   always @(posedge clk) begin
      p0    <= oaddr[0];
      p1[0] <= oaddr[1];
      p1[1] <= p1[0];
      p1[2] <= p1[1];
   end

   function automatic logic [26:0] mem_word(input logic [14:0] a, input bit cm,
                                            input logic [8:0] k0, k1, k2);
      if (cm) return {9'h007, 9'h038, 9'h1C0};
      return {a[8:0] ^ k2, a[8:0] ^ k1, a[8:0] ^ k0};
   endfunction

   assign mem[0] = mem_word(p0,    const_mode, key[0], key[1], key[2]);
   assign mem[1] = mem_word(p1[2], const_mode, key[0], key[1], key[2]);

   sprite_bg_restore u_dut0 (
      .iClock(clk), .iResetn(rst_n), .iStart(start[0]), .iX(ix), .iY(iy),
      .iScreenSel(isel), .iMemData(mem[0]), .oAddress(oaddr[0]), .oX(ox[0]),
      .oY(oy[0]), .oColour(ocol[0]), .oPlot(oplot[0]), .oBusy(obusy[0]),
      .oDone(odone[0])
   );

   sprite_bg_restore #(.SPR_W(4), .SPR_H(2), .MEM_LAT(3)) u_dut1 (
      .iClock(clk), .iResetn(rst_n), .iStart(start[1]), .iX(ix), .iY(iy),
      .iScreenSel(isel), .iMemData(mem[1]), .oAddress(oaddr[1]), .oX(ox[1]),
      .oY(oy[1]), .oColour(ocol[1]), .oPlot(oplot[1]), .oBusy(obusy[1]),
      .oDone(odone[1])
   );

   function automatic int spr_w(input int d); return (d == 0) ? 15 : 4; endfunction
   function automatic int spr_h(input int d); return (d == 0) ? 15 : 2; endfunction
   function automatic int mlat(input int d);  return (d == 0) ? 1 : 3;  endfunction

   function automatic logic [8:0] exp_colour(input int a, input int s);
      logic [14:0] av;
      av = 15'(a);
      if (const_mode) begin
         if (s == 1) return 9'h038;
         if (s == 2) return 9'h007;
         return 9'h1C0;
      end
      return av[8:0] ^ key[s];
   endfunction

   typedef struct {int cyc; int x; int y; logic [8:0] col;} plot_t;

   // One full region restore; cycle 0 is the first SCAN cycle.
   task automatic scan(input int d, input int x, input int y, input int sel, input bit pre,
                       input int pa, input int pb, input bit poke, input bit chain,
                       input int nx, input int ny, input int nsel, input string tag,
                       output int nplots);
      int n, l, se, last, col, row, px, py;
      plot_t q[$];
      int exp_addr[$];
      logic exp_done, exp_busy;
      n  = spr_w(d) * spr_h(d);
      l  = mlat(d);
      se = (sel >= 3) ? 0 : sel;
      for (int k = 0; k < n; k++) begin
         col = k % spr_w(d);
         row = k / spr_w(d);
         px  = x + col;
         py  = y + row;
         if (px < 160 && py < 120) begin
            exp_addr.push_back(py * 160 + px);
            q.push_back('{k + l + 1, px, py, exp_colour(py * 160 + px, se)});
         end else begin
            exp_addr.push_back(0);
         end
      end
      if (!pre) begin
         @(negedge clk);
         ix = 8'(x); iy = 7'(y); isel = 2'(sel); start[d] = 1'b1;
      end
      nplots = 0;
      last   = n + l + 2;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         if (c < n) begin
            checks++;
            if (oaddr[d] !== 15'(exp_addr[c])) begin
               errors++;
               $display("FAIL %s addr c=%0d: got %0d want %0d", tag, c, oaddr[d], exp_addr[c]);
            end
         end
         nplots += int'(oplot[d]);
         checks++;
         if (q.size() > 0 && q[0].cyc == c) begin
            if (oplot[d] !== 1'b1 || ox[d] !== 8'(q[0].x) || oy[d] !== 7'(q[0].y) ||
                ocol[d] !== q[0].col) begin
               errors++;
               $display("FAIL %s plot c=%0d: got p=%0b x=%0d y=%0d col=%h want x=%0d y=%0d col=%h",
                        tag, c, oplot[d], ox[d], oy[d], ocol[d], q[0].x, q[0].y, q[0].col);
            end
            void'(q.pop_front());
         end else if (oplot[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s noplot c=%0d: got oPlot=%0b want 0", tag, c, oplot[d]);
         end
         exp_done = (c == n + l + 1);
         exp_busy = (c <= n + l);
         checks++;
         if (odone[d] !== exp_done) begin
            errors++;
            $display("FAIL %s done c=%0d: got %0b want %0b", tag, c, odone[d], exp_done);
         end
         checks++;
         if (obusy[d] !== exp_busy) begin
            errors++;
            $display("FAIL %s busy c=%0d: got %0b want %0b", tag, c, obusy[d], exp_busy);
         end
         start[d] = 1'b0;
         ix = 8'($urandom); iy = 7'($urandom); isel = 2'($urandom);
         if (c == pa || c == pb) start[d] = 1'b1;
         if (poke && c == n + l + 1) start[d] = 1'b1;
         if (chain && c == last) begin
            start[d] = 1'b1; ix = 8'(nx); iy = 7'(ny); isel = 2'(nsel);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({oaddr[d], ox[d], oy[d], ocol[d], oplot[d], obusy[d], odone[d]} !== '0) begin
            errors++;
            $display("FAIL reset dut%0d: got addr=%0d x=%0d y=%0d col=%h p=%0b b=%0b d=%0b want all 0",
                     d, oaddr[d], ox[d], oy[d], ocol[d], oplot[d], obusy[d], odone[d]);
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int np;
      const_mode = 1'b0;
      key[0] = 9'h000; key[1] = 9'($urandom); key[2] = 9'($urandom);
      scan(0, 10, 20, 0, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "basic", np);
      checks++;
      if (np !== 225) begin
         errors++;
         $display("FAIL basic count: got %0d want 225", np);
      end
   endtask

   task automatic test_clip();
      int np;
      scan(0, 150, 110, 0, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "clip", np);
      checks++;
      if (np !== 100) begin
         errors++;
         $display("FAIL clip count: got %0d want 100", np);
      end
   endtask

   task automatic test_screen_sel();
      int np;
      const_mode = 1'b1;
      scan(0, 40, 50, 2, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "sel2", np);
      scan(0, 90, 10, 3, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "sel3", np);
      const_mode = 1'b0;
   endtask

   task automatic test_ignored_start();
      int np;
      scan(0, 60, 30, 1, 1'b0, 5, 100, 1'b1, 1'b0, 0, 0, 0, "ignore", np);
      checks++;
      if (np !== 225) begin
         errors++;
         $display("FAIL ignore count: got %0d want 225", np);
      end
   endtask

   task automatic test_back_to_back();
      int np;
      scan(0, 5, 5, 2, 1'b0, -1, -1, 1'b0, 1'b1, 100, 70, 1, "b2b_a", np);
      scan(0, 100, 70, 1, 1'b1, -1, -1, 1'b0, 1'b0, 0, 0, 0, "b2b_b", np);
   endtask

   task automatic test_reset_mid();
      int np, bad;
      @(negedge clk);
      ix = 8'd30; iy = 7'd40; isel = 2'd1; start[0] = 1'b1;
      for (int c = 0; c <= 50; c++) begin
         @(negedge clk);
         start[0] = 1'b0;
      end
      checks++;
      if (obusy[0] !== 1'b1) begin
         errors++;
         $display("FAIL midreset busy: got %0b want 1", obusy[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({oaddr[0], ox[0], oy[0], ocol[0], oplot[0], obusy[0], odone[0]} !== '0) begin
         errors++;
         $display("FAIL midreset outputs: got addr=%0d x=%0d y=%0d col=%h p=%0b b=%0b d=%0b want all 0",
                  oaddr[0], ox[0], oy[0], ocol[0], oplot[0], obusy[0], odone[0]);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 240; c++) begin
         @(negedge clk);
         if (oplot[0] !== 1'b0 || odone[0] !== 1'b0 || obusy[0] !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL midreset quiet: got %0d active cycles want 0", bad);
      end
      scan(0, 20, 100, 0, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "after_rst", np);
   endtask

   task automatic test_latency3();
      int np;
      scan(1, 5, 6, 1, 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "lat3", np);
      checks++;
      if (np !== 8) begin
         errors++;
         $display("FAIL lat3 count: got %0d want 8", np);
      end
      scan(1, 158, 119, 2, 1'b0, 3, -1, 1'b0, 1'b0, 0, 0, 0, "lat3_clip", np);
      checks++;
      if (np !== 2) begin
         errors++;
         $display("FAIL lat3_clip count: got %0d want 2", np);
      end
      for (int r = 0; r < 3; r++) begin
         scan(1, int'($urandom_range(0, 170)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 3)), 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "lat3_rand", np);
      end
   endtask

   task automatic test_random();
      int np;
      for (int r = 0; r < 4; r++) begin
         key[0] = 9'($urandom); key[1] = 9'($urandom); key[2] = 9'($urandom);
         scan(0, int'($urandom_range(0, 175)), int'($urandom_range(0, 127)),
              int'($urandom_range(0, 3)), 1'b0, -1, -1, 1'b0, 1'b0, 0, 0, 0, "rand", np);
      end
   endtask

   initial begin
      start = '0; ix = '0; iy = '0; isel = '0;
      const_mode = 1'b0;
      key[0] = '0; key[1] = '0; key[2] = '0;
      test_reset();
      test_basic();
      test_clip();
      test_screen_sel();
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_latency3();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
